// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// A division takes WIDTH RUN cycles followed by a single DONE cycle.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE (busy=0 and done=0). The
  // operands are captured on that edge. busy is then high for WIDTH cycles,
  // and done pulses for one cycle with quotient/remainder/div_by_zero valid.
  // The results hold until the next completed operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] iter;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_shreg;
  logic             q_bit;

  // A set top bit on trial means the subtraction went negative, so restore.
  always_comb begin
    shifted    = (part_rem << 1) | (WIDTH + 1)'(shreg[WIDTH-1]);
    trial      = shifted - {1'b0, dvsr};
    q_bit      = ~trial[WIDTH];
    next_rem   = q_bit ? trial : shifted;
    next_shreg = {shreg[WIDTH-2:0], q_bit};
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      part_rem    <= '0;
      shreg       <= '0;
      dvsr        <= '0;
      iter        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            part_rem <= '0;
            shreg    <= dividend;
            dvsr     <= divisor;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          part_rem <= next_rem;
          shreg    <= next_shreg;
          iter     <= iter + 1'b1;
          if (iter == LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= next_shreg;
            remainder   <= next_rem[WIDTH-1:0];
            div_by_zero <= (dvsr == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
